// File: rtl/exec_datapath.sv
// exec_datapath: fetch/decode/execute core for the 16-bit accumulator ISA.
// One FSM sequences every instruction. Memory is reached through a req/ack
// port whose request fields are captured once and held until acknowledged.
module exec_datapath #(
    parameter int          DWIDTH   = 16,
    parameter int          AWIDTH   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic [AWIDTH-1:0] o_pc,
    output logic [DWIDTH-1:0] o_ac,
    output logic              o_e,
    output logic              o_halt,
    output logic              o_instr_done
);

    localparam logic [AWIDTH-1:0] PC_INIT = AWIDTH'(RESET_PC);
    localparam logic [AWIDTH-1:0] A_ZERO  = {AWIDTH{1'b0}};
    localparam logic [AWIDTH-1:0] A_ONE   = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWIDTH-1:0] D_ZERO  = {DWIDTH{1'b0}};
    localparam logic [DWIDTH-1:0] D_ONE   = {{(DWIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    typedef enum logic [3:0] {
        ST_HALT     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_INDIR    = 4'd3,
        ST_EXEC     = 4'd4,
        ST_EXEC_REG = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_RETIRE   = 4'd8
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [AWIDTH-1:0]   pc_r;
    logic [AWIDTH-1:0]   ar_r;
    logic [DWIDTH-1:0]   ac_r;
    logic [DWIDTH-1:0]   dr_r;
    logic [DWIDTH-1:0]   ir_r;
    logic                e_r;
    logic                halt_pend_r;
    logic                run_armed_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [AWIDTH-1:0]   mem_addr_r;
    logic [DWIDTH-1:0]   mem_wdata_r;
    logic                halt_r;
    logic                done_r;

    logic [2:0]          op_s;
    logic                ind_s;
    logic                xfer_s;
    logic                mem_state_s;
    logic [DWIDTH-1:0]   wdata_sel_s;
    logic [DWIDTH:0]     add_sum_s;

    logic [DWIDTH-1:0]   rr_ac1_s, rr_ac2_s, rr_ac3_s, rr_ac4_s, rr_ac5_s;
    logic                rr_e1_s, rr_e2_s, rr_e3_s, rr_e4_s;
    logic                rr_skip_s;

    assign o_mem_req    = mem_req_r;
    assign o_mem_we     = mem_we_r;
    assign o_mem_addr   = mem_addr_r;
    assign o_mem_wdata  = mem_wdata_r;
    assign o_pc         = pc_r;
    assign o_ac         = ac_r;
    assign o_e          = e_r;
    assign o_halt       = halt_r;
    assign o_instr_done = done_r;

    // Decode fields, transfer strobe, write-data source and adder.
    always_comb begin
        op_s        = ir_r[DWIDTH-2:DWIDTH-4];
        ind_s       = ir_r[DWIDTH-1];
        xfer_s      = mem_req_r & i_mem_ack;
        mem_state_s = (state_r == ST_FETCH) || (state_r == ST_INDIR) ||
                      (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
        add_sum_s   = {1'b0, ac_r} + {1'b0, i_mem_rdata};
        if (op_s == OP_STA) begin
            wdata_sel_s = ac_r;
        end else if (op_s == OP_BSA) begin
            wdata_sel_s = {{(DWIDTH-AWIDTH){1'b0}}, pc_r};
        end else begin
            wdata_sel_s = dr_r;
        end
    end

    // Register-reference micro-ops chained in bit order; skip tests see the result.
    always_comb begin
        rr_ac1_s  = ir_r[11] ? D_ZERO : ac_r;
        rr_e1_s   = ir_r[10] ? 1'b0 : e_r;
        rr_ac2_s  = ir_r[9]  ? ~rr_ac1_s : rr_ac1_s;
        rr_e2_s   = ir_r[8]  ? ~rr_e1_s : rr_e1_s;
        rr_ac3_s  = ir_r[7]  ? {rr_e2_s, rr_ac2_s[DWIDTH-1:1]} : rr_ac2_s;
        rr_e3_s   = ir_r[7]  ? rr_ac2_s[0] : rr_e2_s;
        rr_ac4_s  = ir_r[6]  ? {rr_ac3_s[DWIDTH-2:0], rr_e3_s} : rr_ac3_s;
        rr_e4_s   = ir_r[6]  ? rr_ac3_s[DWIDTH-1] : rr_e3_s;
        rr_ac5_s  = ir_r[5]  ? (rr_ac4_s + D_ONE) : rr_ac4_s;
        rr_skip_s = (ir_r[4] & ~rr_ac5_s[DWIDTH-1]) |
                    (ir_r[3] &  rr_ac5_s[DWIDTH-1]) |
                    (ir_r[2] & (rr_ac5_s == D_ZERO)) |
                    (ir_r[1] & ~rr_e4_s);
    end

    // Next-state logic of the instruction sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (i_run && run_armed_r) next_state_s = ST_FETCH;
                else                      next_state_s = ST_HALT;
            end
            ST_FETCH: begin
                if (xfer_s) next_state_s = ST_DECODE;
                else        next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (op_s == OP_REG) next_state_s = ST_EXEC_REG;
                else if (ind_s)     next_state_s = ST_INDIR;
                else                next_state_s = ST_EXEC;
            end
            ST_INDIR: begin
                if (xfer_s) next_state_s = ST_EXEC;
                else        next_state_s = ST_INDIR;
            end
            ST_EXEC: begin
                case (op_s)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: next_state_s = ST_MEM_RD;
                    OP_STA, OP_BSA:                 next_state_s = ST_MEM_WR;
                    default:                        next_state_s = ST_RETIRE;
                endcase
            end
            ST_EXEC_REG: next_state_s = ST_RETIRE;
            ST_MEM_RD: begin
                if (xfer_s && (op_s == OP_ISZ)) next_state_s = ST_MEM_WR;
                else if (xfer_s)                next_state_s = ST_RETIRE;
                else                            next_state_s = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (xfer_s) next_state_s = ST_RETIRE;
                else        next_state_s = ST_MEM_WR;
            end
            ST_RETIRE: begin
                if (halt_pend_r) next_state_s = ST_HALT;
                else             next_state_s = ST_FETCH;
            end
            default: next_state_s = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_HALT;
        else          state_r <= next_state_s;
    end

    // Memory port: capture request fields one cycle into a memory state, drop on ack.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= A_ZERO;
            mem_wdata_r <= D_ZERO;
        end else if (mem_req_r) begin
            if (i_mem_ack) mem_req_r <= 1'b0;
        end else if (mem_state_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= (state_r == ST_MEM_WR);
            mem_addr_r  <= (state_r == ST_FETCH) ? pc_r : ar_r;
            mem_wdata_r <= wdata_sel_s;
        end
    end

    // Architectural registers updated by each execution step.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r        <= PC_INIT;
            ar_r        <= A_ZERO;
            ac_r        <= D_ZERO;
            dr_r        <= D_ZERO;
            ir_r        <= D_ZERO;
            e_r         <= 1'b0;
            halt_pend_r <= 1'b0;
            run_armed_r <= 1'b1;
        end else begin
            case (state_r)
                ST_HALT: begin
                    // A halt taken with run still high needs run to drop first.
                    if (!i_run) run_armed_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (xfer_s) begin
                        ir_r <= i_mem_rdata;
                        pc_r <= pc_r + A_ONE;
                    end
                end
                ST_DECODE: begin
                    ar_r        <= ir_r[AWIDTH-1:0];
                    halt_pend_r <= 1'b0;
                end
                ST_INDIR: begin
                    if (xfer_s) ar_r <= i_mem_rdata[AWIDTH-1:0];
                end
                ST_EXEC: begin
                    if (op_s == OP_BUN) pc_r <= ar_r;
                end
                ST_EXEC_REG: begin
                    // I/O words (I=1) retire as no-ops.
                    if (!ind_s) begin
                        ac_r        <= rr_ac5_s;
                        e_r         <= rr_e4_s;
                        halt_pend_r <= ir_r[0];
                        if (rr_skip_s) pc_r <= pc_r + A_ONE;
                    end
                end
                ST_MEM_RD: begin
                    if (xfer_s) begin
                        case (op_s)
                            OP_AND:  ac_r <= ac_r & i_mem_rdata;
                            OP_ADD:  {e_r, ac_r} <= add_sum_s;
                            OP_LDA:  ac_r <= i_mem_rdata;
                            OP_ISZ:  dr_r <= i_mem_rdata + D_ONE;
                            default: dr_r <= dr_r;
                        endcase
                    end
                end
                ST_MEM_WR: begin
                    if (xfer_s) begin
                        if (op_s == OP_BSA)                          pc_r <= ar_r + A_ONE;
                        else if ((op_s == OP_ISZ) && (dr_r == D_ZERO)) pc_r <= pc_r + A_ONE;
                    end
                end
                ST_RETIRE: begin
                    if (halt_pend_r) run_armed_r <= 1'b0;
                end
                default: halt_pend_r <= 1'b0;
            endcase
        end
    end

    // Status outputs: halt mirrors the state being entered, done follows retirement.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halt_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            halt_r <= (next_state_s == ST_HALT);
            done_r <= (state_r == ST_RETIRE);
        end
    end

endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: directed programs against an ISA-level reference model,
// with a memory responder that can insert random acknowledge delays.
module tb_exec_datapath;

    logic        clk;
    logic        rst_n, run, mem_req, mem_we, mem_ack, e, halt, done;
    logic [11:0] mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata, ac;

    exec_datapath #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(0)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_run(run),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_pc(pc), .o_ac(ac), .o_e(e), .o_halt(halt), .o_instr_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem  [0:4095];
    logic [15:0] mmem [0:4095];
    logic [11:0] mpc;
    logic [15:0] mac;
    logic        me;
    bit          mhalt;

    int tests, fails;
    int max_delay, wait_left, nreads, nwrites, cyc, ndone;
    bit stall, pend;
    logic [11:0] p_addr;
    logic        p_we;
    logic [15:0] p_wdata;

    int          done_cyc [64];
    logic [11:0] done_pc  [64];
    logic [15:0] done_ac  [64];
    logic        done_e   [64];
    int          done_rd  [64];
    int          done_wr  [64];

    bit          req_prev;
    logic [11:0] h_addr;
    logic        h_we;
    logic [15:0] h_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One instruction of the ISA, straight from the instruction-set rules.
    task automatic model_step();
        logic [15:0] ir, v;
        logic [11:0] ar;
        logic [2:0]  op;
        logic [16:0] sum;
        bit          skip;
        ir  = mmem[mpc];
        mpc = mpc + 12'd1;
        op  = ir[14:12];
        ar  = ir[11:0];
        if (op == 3'd7) begin
            if (!ir[15]) begin
                if (ir[11]) mac = 16'h0000;
                if (ir[10]) me = 1'b0;
                if (ir[9])  mac = ~mac;
                if (ir[8])  me = ~me;
                if (ir[7]) begin v = mac; mac = {me, v[15:1]}; me = v[0]; end
                if (ir[6]) begin v = mac; mac = {v[14:0], me}; me = v[15]; end
                if (ir[5])  mac = mac + 16'd1;
                skip = (ir[4] && !mac[15]) || (ir[3] && mac[15]) ||
                       (ir[2] && mac == 16'h0000) || (ir[1] && !me);
                if (skip)   mpc = mpc + 12'd1;
                if (ir[0])  mhalt = 1'b1;
            end
        end else begin
            if (ir[15]) begin v = mmem[ar]; ar = v[11:0]; end
            case (op)
                3'd0: mac = mac & mmem[ar];
                3'd1: begin sum = {1'b0, mac} + {1'b0, mmem[ar]}; me = sum[16]; mac = sum[15:0]; end
                3'd2: mac = mmem[ar];
                3'd3: mmem[ar] = mac;
                3'd4: mpc = ar;
                3'd5: begin mmem[ar] = {4'h0, mpc}; mpc = ar + 12'd1; end
                default: begin
                    v = mmem[ar] + 16'd1;
                    mmem[ar] = v;
                    if (v == 16'h0000) mpc = mpc + 12'd1;
                end
            endcase
        end
    endtask

    // Memory responder: ack after wait_left cycles, commit on the sampled edge.
    initial begin
        mem_ack = 1'b0; mem_rdata = 16'h0000; pend = 1'b0; wait_left = 0;
        forever begin
            @(posedge clk);
            if (pend && rst_n) begin
                if (p_we) begin mem[p_addr] = p_wdata; nwrites++; end
                else nreads++;
                wait_left = (max_delay > 0) ? $urandom_range(0, max_delay) : 0;
            end
            pend = 1'b0;
            #1;
            if (rst_n && mem_req && !stall) begin
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_we ? 16'h0000 : mem[mem_addr];
                    pend = 1'b1; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
                end else begin
                    mem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Compare process: request stability every cycle, architectural state at each retirement.
    initial begin
        cyc = 0; req_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                req_prev = 1'b0;
            end else begin
                if (mem_req && req_prev) begin
                    chk("req_addr_stable", 32'(mem_addr), 32'(h_addr));
                    chk("req_we_stable", 32'(mem_we), 32'(h_we));
                    chk("req_wdata_stable", 32'(mem_wdata), 32'(h_wdata));
                end
                req_prev = mem_req; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                if (done) begin
                    model_step();
                    if (ndone < 64) begin
                        done_cyc[ndone] = cyc; done_pc[ndone] = pc; done_ac[ndone] = ac;
                        done_e[ndone] = e; done_rd[ndone] = nreads; done_wr[ndone] = nwrites;
                    end
                    ndone++;
                    chk("retire_pc", 32'(pc), 32'(mpc));
                    chk("retire_ac", 32'(ac), 32'(mac));
                    chk("retire_e", 32'(e), 32'(me));
                    chk("retire_halt", 32'(halt), 32'(mhalt));
                end
            end
        end
    end

    task automatic put(input int a, input logic [15:0] v);
        mem[a] = v;
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        case (p)
            2: begin put(0, 16'h2010); put(1, 16'h1011); put(2, 16'h7001); put(3, 16'h7001);
                     put(16'h10, 16'h7FFF); put(16'h11, 16'h0001); end
            3: begin put(0, 16'hA020); put(1, 16'h7001); put(16'h20, 16'h0030); put(16'h30, 16'h1234); end
            4: begin put(0, 16'h6040); put(1, 16'h7001); put(2, 16'h7001); put(16'h40, 16'hFFFF); end
            5: begin put(0, 16'h6040); put(1, 16'h7001); put(2, 16'h7001); put(16'h40, 16'h0005); end
            6: begin for (int i = 0; i < 4; i++) put(i, 16'h7000);
                     put(4, 16'h5050); put(16'h51, 16'h7001); end
            7: begin put(0, 16'h7800); put(1, 16'h6040); put(2, 16'hA020); put(3, 16'h2010); put(4, 16'h7001);
                     put(16'h40, 16'h0005); put(16'h20, 16'h0030); put(16'h30, 16'h1234); put(16'h10, 16'h4321); end
            default: begin
                put(0, 16'h2010); put(1, 16'h0011); put(2, 16'h7080); put(3, 16'h7040); put(4, 16'h7300);
                put(5, 16'h7020); put(6, 16'h7010); put(7, 16'h7001); put(8, 16'h7C04); put(9, 16'h7001);
                put(10, 16'h7002); put(11, 16'h7001); put(12, 16'h7001);
                put(16'h10, 16'h80F1); put(16'h11, 16'h800F);
            end
        endcase
    endtask

    task automatic start_run(input int d);
        @(negedge clk);
        run = 1'b0; rst_n = 1'b0; max_delay = d; stall = 1'b0; wait_left = 0;
        for (int i = 0; i < 4096; i++) mmem[i] = mem[i];
        mpc = 12'h000; mac = 16'h0000; me = 1'b0; mhalt = 1'b0;
        nreads = 0; nwrites = 0; ndone = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); run = 1'b1;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!(mhalt && halt) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL timeout_%s: no halt after %0d cycles, expected halt", name, n);
        end
    endtask

    task automatic mem_vs_model();
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== mmem[i]) bad++;
        chk("mem_vs_model", 32'(bad), 32'h0);
    endtask

    task automatic run_prog(input int p, input int d);
        load_prog(p);
        start_run(d);
        wait_halt($sformatf("prog%0d_d%0d", p, d));
        mem_vs_model();
        case (p)
            2: begin
                chk("p2_ac", 32'(ac), 32'h8000); chk("p2_e", 32'(e), 32'h0);
                chk("p2_pc", 32'(pc), 32'h3); chk("p2_lda_ac", 32'(done_ac[0]), 32'h7FFF);
                if (d == 0) begin
                    chk("lat_add", 32'(done_cyc[1] - done_cyc[0]), 32'd7);
                    chk("lat_regref", 32'(done_cyc[2] - done_cyc[1]), 32'd5);
                end
                repeat (8) @(negedge clk);
                chk("hlt_stays_halt", 32'(halt), 32'h1);
                chk("hlt_stays_pc", 32'(pc), 32'h3);
                chk("hlt_no_req", 32'(mem_req), 32'h0);
                run = 1'b0; mhalt = 1'b0;
                repeat (2) @(negedge clk);
                run = 1'b1;
                wait_halt("rerun");
                chk("rerun_pc", 32'(pc), 32'h4);
            end
            3: begin
                chk("p3_ac", 32'(ac), 32'h1234);
                chk("p3_reads", 32'(done_rd[0]), 32'd3);
                chk("p3_pc", 32'(pc), 32'h2);
            end
            4: begin
                chk("isz_wrap_pc", 32'(done_pc[0]), 32'h2);
                chk("isz_wrap_mem", 32'(mem[16'h40]), 32'h0);
                chk("isz_wrap_wr", 32'(done_wr[0]), 32'd1);
            end
            5: begin
                chk("isz_pc", 32'(done_pc[0]), 32'h1);
                chk("isz_mem", 32'(mem[16'h40]), 32'h6);
            end
            6: begin
                chk("bsa_pc", 32'(done_pc[4]), 32'h51);
                chk("bsa_mem", 32'(mem[16'h50]), 32'h5);
                chk("bsa_final_pc", 32'(pc), 32'h52);
            end
            7: begin
                chk("p7_ac", 32'(ac), 32'h4321);
                chk("p7_mem", 32'(mem[16'h40]), 32'h6);
                if (d == 0) begin
                    chk("lat_isz", 32'(done_cyc[1] - done_cyc[0]), 32'd9);
                    chk("lat_lda_ind", 32'(done_cyc[2] - done_cyc[1]), 32'd9);
                    chk("lat_lda", 32'(done_cyc[3] - done_cyc[2]), 32'd7);
                    chk("lat_hlt", 32'(done_cyc[4] - done_cyc[3]), 32'd5);
                end
            end
            default: begin
                chk("rr_and_ac", 32'(done_ac[1]), 32'h8001);
                chk("rr_cir_ac", 32'(done_ac[2]), 32'h4000);
                chk("rr_cir_e", 32'(done_e[2]), 32'h1);
                chk("rr_cil_ac", 32'(done_ac[3]), 32'h8001);
                chk("rr_inc_ac", 32'(done_ac[5]), 32'h7FFF);
                chk("rr_spa_pc", 32'(done_pc[6]), 32'h8);
                chk("rr_final_ac", 32'(ac), 32'h0);
                chk("rr_final_e", 32'(e), 32'h0);
                chk("rr_final_pc", 32'(pc), 32'hD);
            end
        endcase
    endtask

    // Directed sequence: reset values, reset mid-fetch, then every program at zero and random wait.
    initial begin
        int n;
        tests = 0; fails = 0; rst_n = 1'b0; run = 1'b0; max_delay = 0; stall = 1'b0; ndone = 0;
        nreads = 0; nwrites = 0; mhalt = 1'b0; mpc = 12'h000; mac = 16'h0000; me = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ac", 32'(ac), 32'h0);
        chk("rst_e", 32'(e), 32'h0);
        chk("rst_halt", 32'(halt), 32'h1);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        stall = 1'b1; run = 1'b1; n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        chk("midfetch_req_seen", 32'(mem_req), 32'h1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midfetch_req", 32'(mem_req), 32'h0);
        chk("midfetch_pc", 32'(pc), 32'h0);
        chk("midfetch_halt", 32'(halt), 32'h1);
        chk("midfetch_ac", 32'(ac), 32'h0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;

        for (int d = 0; d <= 5; d += 5)
            for (int p = 2; p <= 8; p++)
                run_prog(p, d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
